// File: rtl/booth_sequential_multiplier.sv
// Iterative radix-2 multiplier. One add/sub step and one shift step per multiplier bit.
// `define MULT_SIGNED_EN selects two's-complement Booth recoding; otherwise unsigned shift-add.
module booth_sequential_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ADDSUB = 3'd2,
    SHIFT  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   acc, acc_nxt, m_ext;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;
  logic             last;
`ifdef MULT_SIGNED_EN
  logic             q_m1;
`endif

  assign last = (count == CW'(WIDTH-1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = ADDSUB;
      ADDSUB:  state_nxt = SHIFT;
      SHIFT:   state_nxt = last ? DONE : ADDSUB;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Extra accumulator bit absorbs the carry / keeps -M representable for M = -2^(WIDTH-1).
  always_comb begin
    acc_nxt = acc;
`ifdef MULT_SIGNED_EN
    unique case ({q[0], q_m1})
      2'b10:   acc_nxt = acc - m_ext;
      2'b01:   acc_nxt = acc + m_ext;
      default: acc_nxt = acc;
    endcase
`else
    if (q[0]) acc_nxt = acc + m_ext;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      q       <= '0;
      m_ext   <= '0;
      count   <= '0;
      product <= '0;
`ifdef MULT_SIGNED_EN
      q_m1    <= 1'b0;
`endif
    end else begin
      unique case (state)
        LOAD: begin
          acc   <= '0;
          q     <= multiplier;
          count <= '0;
`ifdef MULT_SIGNED_EN
          m_ext <= {multiplicand[WIDTH-1], multiplicand};
          q_m1  <= 1'b0;
`else
          m_ext <= {1'b0, multiplicand};
`endif
        end
        ADDSUB: acc <= acc_nxt;
        SHIFT: begin
`ifdef MULT_SIGNED_EN
          {acc, q, q_m1} <= {acc[WIDTH], acc, q};
`else
          {acc, q} <= {1'b0, acc, q[WIDTH-1:1]};
`endif
          // Product is the post-shift {A[WIDTH-1:0],Q}, registered so it is valid in DONE.
          if (last) product <= {acc, q[WIDTH-1:1]};
          else      count   <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_sequential_multiplier.sv
// Directed bench for booth_sequential_multiplier (WIDTH=8), scoreboard of expected products.
module tb_booth_sequential_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        busy, done;
  logic [15:0] product;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb[$];

  booth_sequential_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] m, input logic [7:0] q);
`ifdef MULT_SIGNED_EN
    logic signed [15:0] sm, sq;
    sm = {{8{m[7]}}, m};
    sq = {{8{q[7]}}, q};
    return 16'(sm * sq);
`else
    return {8'h00, m} * {8'h00, q};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Operands are scrambled after LOAD.
  task automatic op(input logic [7:0] m, input logic [7:0] q, input string tag, input bit glitch);
    int n, bcnt;
    logic [15:0] exp;
    exp = model(m, q);
    sb.push_back(exp);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    n = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      n++;
      start = glitch && (n == 4 || n == 11);
      if (n >= 2) begin
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
      end
      if (busy) bcnt++;
    end while (!done && n < 60);
    start = 1'b0;
    chk({tag, " latency"}, n, 18);
    chk({tag, " busy cycles"}, bcnt, 18);
    chk({tag, " product"}, product, (sb.size() != 0) ? sb.pop_front() : 16'hxxxx);
    @(negedge clk);
    chk({tag, " done pulse width"}, {31'd0, done}, 0);
    chk({tag, " busy after done"}, {31'd0, busy}, 0);
    chk({tag, " product hold"}, product, exp);
    if (glitch) begin
      bcnt = 0;
      repeat (25) begin
        @(negedge clk);
        if (busy || done) bcnt++;
      end
      chk({tag, " no second op"}, bcnt, 0);
    end
  endtask

  initial begin
    int n, t1, t2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset product", product, 0);
    rst_n = 1'b1;
    @(negedge clk);

    op(8'd7,   8'd3,   "m7q3",    1'b0);
    op(8'hFF,  8'hFF,  "mffqff",  1'b0);
    op(8'hFB,  8'h07,  "mfbq07",  1'b0);
    op(8'h80,  8'h80,  "m80q80",  1'b0);
    op(8'h00,  8'hA5,  "m00qa5",  1'b0);
    op(8'h12,  8'h34,  "glitch",  1'b1);

    // start held high: two back-to-back operations
    sb.push_back(model(8'h0D, 8'h0B));
    multiplicand = 8'h0D;
    multiplier   = 8'h0B;
    start = 1'b1;
    n = 0; t1 = 0; t2 = 0;
    do begin
      @(negedge clk);
      n++;
      if (done) begin
        if (t1 == 0) begin
          t1 = n;
          chk("held first product", product, (sb.size() != 0) ? sb.pop_front() : 16'hxxxx);
          multiplicand = 8'h21;
          multiplier   = 8'h03;
          sb.push_back(model(8'h21, 8'h03));
        end else begin
          t2 = n;
          chk("held second product", product, (sb.size() != 0) ? sb.pop_front() : 16'hxxxx);
          start = 1'b0;
        end
      end
    end while (t2 == 0 && n < 80);
    start = 1'b0;
    chk("held first latency", t1, 18);
    chk("held spacing", t2 - t1, 19);
    repeat (3) @(negedge clk);
    chk("held stops", {31'd0, busy}, 0);

    // reset during the 6th iteration cycle
    sb.delete();
    multiplicand = 8'h55;
    multiplier   = 8'h66;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", {31'd0, busy}, 0);
    chk("mid reset done", {31'd0, done}, 0);
    chk("mid reset product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(8'd3, 8'd4, "post reset m3q4", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_sequential_multiplier.md
# booth_sequential_multiplier

Iterative radix-2 multiplier: the inverse-operation companion to the team's non-restoring divider, using the same start/done sequencing style. Controller FSM and datapath (accumulator A, multiplier register Q, Booth bit Q₋₁, iteration counter) live in one module. Returns a 2·WIDTH-bit product after a fixed number of cycles. Sits beside the divider in the arithmetic unit and is driven by the same top-level sequencer.

## Interface
- WIDTH, 8: operand width in bits; legal range 4–32.
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiplication; sampled only in IDLE.
- multiplicand  input  WIDTH  operand M; captured in LOAD.
- multiplier  input  WIDTH  operand Q; captured in LOAD.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in DONE; product valid from that cycle on.
- product  output  2·WIDTH  result register; holds its value until the next DONE.

## Operation
- States:
  - IDLE: if start=1, go to LOAD; otherwise stay in IDLE.
  - LOAD: go to ADDSUB.
  - ADDSUB: go to SHIFT.
  - SHIFT: go to DONE if count==WIDTH−1; otherwise increment count and go to ADDSUB.
  - DONE: go to IDLE.
- LOAD captures M and Q.
  - A is WIDTH+1 bits. A←0, Q₋₁←0, count←0.
  - Signed mode: M is sign-extended to WIDTH+1 bits. Unsigned mode: M is zero-extended.
- ADDSUB, signed mode, by pair (Q[0],Q₋₁):
  - 10: A←A−M.
  - 01: A←A+M.
  - 00 or 11: A unchanged.
- SHIFT, signed mode: arithmetic right shift of {A,Q,Q₋₁} by one; A's MSB is replicated.
- ADDSUB, unsigned mode: if Q[0]=1, A←A+M. The carry lands in A[WIDTH].
- SHIFT, unsigned mode: logical right shift of {A,Q}; 0 enters at the top.
- DONE: product←{A[WIDTH−1:0],Q}; done=1.
- Arithmetic is modulo 2^(WIDTH+1) in A. The extra A bit guarantees no overflow, including M = −2^(WIDTH−1).
- start in any state other than IDLE is ignored; no queueing.
- start held high through DONE begins a new operation on the cycle after DONE; the IDLE→LOAD edge is taken normally.
- Operand inputs are sampled only in LOAD. Changing them afterwards does not affect the operation in flight.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0, done=0, product=0.
  - A, Q, Q₋₁, M and count are all cleared.
  - Takes effect immediately, including mid-operation. The in-flight result is discarded and product reads 0.
- Latency: start sampled high at edge E0 → LOAD in cycle 1 → 2·WIDTH iteration cycles → DONE in cycle 2·WIDTH+2 after E0.
  - WIDTH=8: done is high in cycle 18.
- Back-to-back throughput: one result per 2·WIDTH+3 cycles (the extra cycle is the IDLE visit).
- busy rises in the LOAD cycle and falls in the cycle after DONE.
- done and product are registered outputs, with no combinational path from inputs.

## Configuration
- MULT_SIGNED_EN
  - Defined: operands and product are two's complement, with Booth recoding and arithmetic shift as above.
  - Undefined: operands and product are unsigned, using shift-add with carry into A[WIDTH] and logical shift.
  - Latency, ports and FSM are identical in both builds.

## Test plan
- Unsigned build, WIDTH=8, start with M=7, Q=3 → done in cycle 18, product=0x0015. Then M=255, Q=255 → product=0xFE01.
- Signed build, WIDTH=8:
  - M=−5 (0xFB), Q=7 → product=0xFFDD (−35).
  - M=0x80, Q=0x80 → product=0x4000 (16384).
- Both builds: M=0, Q=0xA5 → product=0x0000. busy is high for exactly 18 cycles (LOAD through DONE) and done pulses for exactly 1 cycle.
- start pulsed again in ITER cycles 3 and 10 with different operands → first result unchanged, no second operation. start held high continuously → two results 19 cycles apart.
- rst_n driven low in the 6th iteration cycle → busy=0, done=0, product=0 immediately. A new start after release with M=3, Q=4 → product=12.
- Operands changed on the cycle after LOAD → product still reflects the values captured in LOAD.
